video_mnist_color_ctl: RTL

//  Register-bus controller for the MNIST colour-overlay core. Software writes shadow copies of

---
 rtl/video_mnist_color_ctl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/video_mnist_color_ctl.sv
// Wishbone control block for the MNIST colour overlay. Software writes shadow
// mode/threshold registers, which are copied to the live outputs at a frame start
// snooped from an AXI4-Stream handshake, with an optional watchdog forcing the copy.
// Ports: aclk/areset (sync, active-high); s_wb_* 0-wait Wishbone slave;
//        mon_tuser/tvalid/tready snooped stream; param_mode/param_th live outputs.
module video_mnist_color_ctl #(
  parameter int          WB_ADR_WIDTH = 8,
  parameter int          WB_DAT_WIDTH = 32,
  parameter int          TCOUNT_WIDTH = 4,
  parameter logic [31:0] CORE_ID      = 32'h527a_3100,
  parameter logic [2:0]  INIT_MODE    = 3'b010,
  parameter logic [TCOUNT_WIDTH-1:0] INIT_TH = 4'd8,
  parameter logic [31:0] INIT_TIMEOUT = 32'd0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic                      s_wb_we_i,
  input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,
  input  logic                      mon_tuser,
  input  logic                      mon_tvalid,
  input  logic                      mon_tready,
  output logic [2:0]                param_mode,
  output logic [TCOUNT_WIDTH-1:0]   param_th
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [WB_ADR_WIDTH-1:0] A_ID      = WB_ADR_WIDTH'(0);
  localparam logic [WB_ADR_WIDTH-1:0] A_CONTROL = WB_ADR_WIDTH'(1);
  localparam logic [WB_ADR_WIDTH-1:0] A_STATUS  = WB_ADR_WIDTH'(2);
  localparam logic [WB_ADR_WIDTH-1:0] A_FCOUNT  = WB_ADR_WIDTH'(3);
  localparam logic [WB_ADR_WIDTH-1:0] A_MODE    = WB_ADR_WIDTH'(4);
  localparam logic [WB_ADR_WIDTH-1:0] A_TH      = WB_ADR_WIDTH'(5);
  localparam logic [WB_ADR_WIDTH-1:0] A_TIMEOUT = WB_ADR_WIDTH'(6);

  state_t                   state_q, state_d;
  logic [31:0]              wdog_q, wdog_d;
  logic                     flag_q, flag_d;
  logic [31:0]              frame_cnt_q, frame_cnt_d;
  logic [2:0]               mode_sh_q, mode_sh_d;
  logic [TCOUNT_WIDTH-1:0]  th_sh_q, th_sh_d;
  logic [31:0]              timeout_q, timeout_d;
  logic [2:0]               param_mode_q, param_mode_d;
  logic [TCOUNT_WIDTH-1:0]  param_th_q, param_th_d;

  logic        wr;
  logic        sof;
  logic        ctrl_req;
  logic        ctrl_imm;
  logic        flag_clr;
  logic        apply;
  logic        apply_to;
  logic [31:0] wdat;
  logic [3:0]  wsel;
  logic [31:0] mode_mrg;
  logic [31:0] th_mrg;
  logic [31:0] rdata;

  // Byte-lane merge of a write into a 32-bit register image.
  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] dat,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    end
    return r;
  endfunction

  assign s_wb_ack_o = s_wb_stb_i;
  assign param_mode = param_mode_q;
  assign param_th   = param_th_q;

  assign wr   = s_wb_stb_i & s_wb_we_i;
  assign sof  = mon_tvalid & mon_tready & mon_tuser;
  assign wdat = s_wb_dat_i[31:0];
  assign wsel = s_wb_sel_i[3:0];

  assign ctrl_req = wr & (s_wb_adr_i == A_CONTROL) & wsel[0] & wdat[0];
  assign ctrl_imm = wdat[1];
  assign flag_clr = wr & (s_wb_adr_i == A_STATUS) & wsel[0] & wdat[1];

  assign mode_mrg = merge({29'd0, mode_sh_q}, wdat, wsel);
  assign th_mrg   = merge({{(32-TCOUNT_WIDTH){1'b0}}, th_sh_q}, wdat, wsel);

  // Shadow registers, timeout limit and frame counter.
  always_comb begin
    mode_sh_d   = mode_sh_q;
    th_sh_d     = th_sh_q;
    timeout_d   = timeout_q;
    frame_cnt_d = frame_cnt_q;
    if (wr && s_wb_adr_i == A_MODE)    mode_sh_d = mode_mrg[2:0];
    if (wr && s_wb_adr_i == A_TH)      th_sh_d   = th_mrg[TCOUNT_WIDTH-1:0];
    if (wr && s_wb_adr_i == A_TIMEOUT) timeout_d = merge(timeout_q, wdat, wsel);
    if (sof) frame_cnt_d = frame_cnt_q + 32'd1;
  end

  // Update FSM. A new request always re-arms, even when an apply lands on the
  // same edge; a sof coinciding with the timeout counts as a normal frame apply.
  always_comb begin
    state_d  = state_q;
    wdog_d   = wdog_q;
    apply    = 1'b0;
    apply_to = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_req) begin
          if (ctrl_imm) begin
            apply = 1'b1;
          end else begin
            state_d = ST_PEND;
            wdog_d  = 32'd0;
          end
        end
      end
      ST_PEND: begin
        wdog_d = wdog_q + 32'd1;
        if (sof) begin
          apply   = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout_q != 32'd0 &&
                     wdog_q == timeout_q - 32'd1) begin
          apply    = 1'b1;
          apply_to = 1'b1;
          state_d  = ST_IDLE;
        end
        if (ctrl_req) begin
          state_d = ST_PEND;
          wdog_d  = 32'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Live outputs take the pre-write shadow value on an apply edge.
  always_comb begin
    param_mode_d = param_mode_q;
    param_th_d   = param_th_q;
    flag_d       = flag_q;
    if (apply) begin
      param_mode_d = mode_sh_q;
      param_th_d   = th_sh_q;
    end
    if (flag_clr) flag_d = 1'b0;
    if (apply_to) flag_d = 1'b1;
  end

  always_comb begin
    rdata = 32'd0;
    unique case (s_wb_adr_i)
      A_ID:      rdata = CORE_ID;
      A_CONTROL: rdata = {31'd0, state_q == ST_PEND};
      A_STATUS:  rdata = {30'd0, flag_q, state_q == ST_PEND};
      A_FCOUNT:  rdata = frame_cnt_q;
      A_MODE:    rdata = {29'd0, mode_sh_q};
      A_TH:      rdata = {{(32-TCOUNT_WIDTH){1'b0}}, th_sh_q};
      A_TIMEOUT: rdata = timeout_q;
      default:   rdata = 32'd0;
    endcase
    s_wb_dat_o       = '0;
    s_wb_dat_o[31:0] = rdata;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      wdog_q       <= 32'd0;
      flag_q       <= 1'b0;
      frame_cnt_q  <= 32'd0;
      mode_sh_q    <= INIT_MODE;
      th_sh_q      <= INIT_TH;
      timeout_q    <= INIT_TIMEOUT;
      param_mode_q <= INIT_MODE;
      param_th_q   <= INIT_TH;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      flag_q       <= flag_d;
      frame_cnt_q  <= frame_cnt_d;
      mode_sh_q    <= mode_sh_d;
      th_sh_q      <= th_sh_d;
      timeout_q    <= timeout_d;
      param_mode_q <= param_mode_d;
      param_th_q   <= param_th_d;
    end
  end

endmodule
